mux_serializer_8: RTL and testbench

- Byte-wide parallel-to-serial converter.
- Latches an 8-bit word with a valid/ready handshake, then walks a 3-bit bit-index through all eight positions.
- Each serial bit is selected by an internal mux_8x1 (the team's 2x1-tree mux) driven by the registered byte and the bit-index.
- Sits directly upstream of any serial consumer (shift-out link, LED scanner, UART-style framer) and is the natural sequencer that drives the mux select lines.

---
 rtl/mux_serializer_8_pkg.sv | 13 +
 rtl/mux_8x1.sv | 24 ++
 rtl/mux_serializer_8.sv | 118 +++++++++++
 tb/tb_mux_serializer_8.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_8_pkg.sv
// Shared definitions for the byte serializer: FSM state encoding and datapath widths.
package mux_serializer_8_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_8x1.sv
// 8:1 bit multiplexer built as a three-level tree of 2:1 selects.
module mux_8x1
  import mux_serializer_8_pkg::*;
(
  input  logic [BYTE_W-1:0] in_i,
  input  logic [IDX_W-1:0]  sel_i,
  output logic              y_o
);

  logic [3:0] lvl1;
  logic [1:0] lvl2;

  // Tree of 2:1 selects: sel[0] picks within pairs, sel[1] within quads, sel[2] the half.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lvl1[j] = sel_i[0] ? in_i[2*j+1] : in_i[2*j];
    end
    for (int j = 0; j < 2; j++) begin
      lvl2[j] = sel_i[1] ? lvl1[2*j+1] : lvl1[2*j];
    end
    y_o = sel_i[2] ? lvl2[1] : lvl2[0];
  end

endmodule

// File: rtl/mux_serializer_8.sv
// Byte-wide parallel-to-serial converter: latches a byte over a valid/ready
// handshake and walks a bit index through the mux_8x1 select lines.
module mux_serializer_8
  import mux_serializer_8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter int FRAME_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BYTE_W-1:0] data_in,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_last,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              busy
);

  localparam int GAP_W = ($clog2(FRAME_GAP + 1) > 1) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  byte_q,  byte_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [IDX_W-1:0]   beat_q,  beat_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               raw_bit;
  logic               accept;

  mux_8x1 u_mux (
    .in_i  (byte_q),
    .sel_i (idx_q),
    .y_o   (raw_bit)
  );

  // Handshake and observation outputs decoded straight from registered state.
  always_comb begin
    ser_valid  = (state_q == SHIFT);
    ser_last   = ser_valid && (beat_q == 3'd7);
    busy       = (state_q != IDLE);
    bit_idx    = idx_q;
    ser_out    = ser_valid & raw_bit;
    load_ready = !rst && ((state_q == IDLE) ||
                          (ser_last && ser_ready && (FRAME_GAP == 0)));
    accept     = load_valid && load_ready;
  end

  // Next-state logic: load, step through the byte, optionally idle for the frame gap.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d  = data_in;
          idx_d   = IDX_START;
          beat_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (beat_q == 3'd7) begin
            beat_d = '0;
            if (FRAME_GAP == 0) begin
              if (accept) begin
                byte_d = data_in;
                idx_d  = IDX_START;
              end else begin
                state_d = IDLE;
              end
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end else begin
            // The index never wraps here; only a reload returns it to the start.
            idx_d  = MSB_FIRST ? (idx_q - 3'd1) : (idx_q + 3'd1);
            beat_d = beat_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      idx_q   <= IDX_START;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_mux_serializer_8.sv
// Directed bench for mux_serializer_8 with a per-instance bit scoreboard.
// Instance 0: LSB first, no gap. Instance 1: MSB first. Instance 2: LSB first, 2-cycle gap.
module tb_mux_serializer_8;

  typedef struct packed {
    logic       b;
    logic       l;
    logic [2:0] i;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lv, rdy, lr, sv, so, sl, bsy;
  logic [7:0] din [3];
  logic [2:0] idx [3];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  exp_t sbq [3][$];

  always #5 clk = ~clk;

  mux_serializer_8 #(.MSB_FIRST(1'b0), .FRAME_GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .data_in(din[0]),
    .ser_valid(sv[0]), .ser_ready(rdy[0]), .ser_out(so[0]), .ser_last(sl[0]),
    .bit_idx(idx[0]), .busy(bsy[0]));

  mux_serializer_8 #(.MSB_FIRST(1'b1), .FRAME_GAP(0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .data_in(din[1]),
    .ser_valid(sv[1]), .ser_ready(rdy[1]), .ser_out(so[1]), .ser_last(sl[1]),
    .bit_idx(idx[1]), .busy(bsy[1]));

  mux_serializer_8 #(.MSB_FIRST(1'b0), .FRAME_GAP(2)) u_gap (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .data_in(din[2]),
    .ser_valid(sv[2]), .ser_ready(rdy[2]), .ser_out(so[2]), .ser_last(sl[2]),
    .bit_idx(idx[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bit sequence of one accepted byte, in transmit order.
  task automatic push_byte(input int k, input logic [7:0] b);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.i = (k == 1) ? 3'(7 - i) : 3'(i);
      e.b = b[e.i];
      e.l = (i == 7);
      sbq[k].push_back(e);
    end
  endtask

  // Called at the falling edge: score transfers due at the next rising edge.
  task automatic sb();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (sv[k] && rdy[k]) begin
        if (sbq[k].size() == 0) begin
          chk($sformatf("sb_extra_bit[%0d]", k), 32'(sv[k]), 32'd0);
        end else begin
          e = sbq[k].pop_front();
          chk($sformatf("sb_bit[%0d]", k),  32'(so[k]),  32'(e.b));
          chk($sformatf("sb_last[%0d]", k), 32'(sl[k]),  32'(e.l));
          chk($sformatf("sb_idx[%0d]", k),  32'(idx[k]), 32'(e.i));
        end
      end else if (!sv[k]) begin
        chk($sformatf("idle_out[%0d]", k),  32'(so[k]), 32'd0);
        chk($sformatf("idle_last[%0d]", k), 32'(sl[k]), 32'd0);
      end
      if (lv[k] && lr[k]) push_byte(k, din[k]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    sb();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat_a5 [8];
    logic [7:0] pat_c3 [8];
    logic [7:0] pat_bb [16];
    pat_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    pat_c3 = '{1, 1, 0, 0, 0, 0, 1, 1};
    pat_bb = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    rst = 1'b1;
    lv  = '0;
    rdy = '1;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;

    // Reset state
    adv();
    sample();
    for (int k = 0; k < 3; k++) begin
      chk("rst_load_ready", 32'(lr[k]), 32'd0);
      chk("rst_valid", 32'(sv[k]), 32'd0);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_idx", 32'(idx[k]), (k == 1) ? 32'd7 : 32'd0);
    end
    adv();
    rst = 1'b0;

    // 1: LSB first, 8'hA5
    din[0] = 8'hA5;
    lv[0]  = 1'b1;
    sample();
    chk("t1_ready_idle", 32'(lr[0]), 32'd1);
    adv();
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t1_valid", 32'(sv[0]), 32'd1);
      chk("t1_busy", 32'(bsy[0]), 32'd1);
      chk("t1_out", 32'(so[0]), 32'(pat_a5[i]));
      chk("t1_idx", 32'(idx[0]), 32'(i));
      chk("t1_last", 32'(sl[0]), (i == 7) ? 32'd1 : 32'd0);
      adv();
    end
    sample();
    chk("t1_busy_after", 32'(bsy[0]), 32'd0);
    chk("t1_valid_after", 32'(sv[0]), 32'd0);
    adv();

    // 2: MSB first, 8'hC3
    din[1] = 8'hC3;
    lv[1]  = 1'b1;
    sample();
    adv();
    lv[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t2_out", 32'(so[1]), 32'(pat_c3[i]));
      chk("t2_idx", 32'(idx[1]), 32'(7 - i));
      chk("t2_last", 32'(sl[1]), (i == 7) ? 32'd1 : 32'd0);
      adv();
    end
    sample();
    chk("t2_busy_after", 32'(bsy[1]), 32'd0);
    adv();

    // 3: back-to-back 8'h0F then 8'hF0
    din[0] = 8'h0F;
    lv[0]  = 1'b1;
    sample();
    adv();
    din[0] = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("t3_valid", 32'(sv[0]), 32'd1);
      chk("t3_out", 32'(so[0]), 32'(pat_bb[i]));
      chk("t3_ready", 32'(lr[0]), (i == 7 || i == 15) ? 32'd1 : 32'd0);
      adv();
      if (i == 7) lv[0] = 1'b0;
    end
    sample();
    chk("t3_busy_after", 32'(bsy[0]), 32'd0);
    adv();

    // 4: backpressure on 8'h81 at bit index 3
    din[0] = 8'h81;
    lv[0]  = 1'b1;
    sample();
    adv();
    lv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      adv();
    end
    rdy[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sample();
      chk("t4_hold_idx", 32'(idx[0]), 32'd3);
      chk("t4_hold_out", 32'(so[0]), 32'd0);
      chk("t4_hold_valid", 32'(sv[0]), 32'd1);
      chk("t4_hold_last", 32'(sl[0]), 32'd0);
      adv();
    end
    rdy[0] = 1'b1;
    for (int i = 3; i < 8; i++) begin
      sample();
      chk("t4_idx", 32'(idx[0]), 32'(i));
      if (i == 7) begin
        chk("t4_final_out", 32'(so[0]), 32'd1);
        chk("t4_final_last", 32'(sl[0]), 32'd1);
      end
      adv();
    end
    sample();
    chk("t4_busy_after", 32'(bsy[0]), 32'd0);
    adv();

    // 5: FRAME_GAP=2, two 8'hFF bytes with load_valid held
    din[2] = 8'hFF;
    lv[2]  = 1'b1;
    sample();
    adv();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) begin
        sample();
        chk("t5_valid", 32'(sv[2]), 32'd1);
        chk("t5_out", 32'(so[2]), 32'd1);
        chk("t5_ready_shift", 32'(lr[2]), 32'd0);
        adv();
      end
      for (int g = 0; g < 2; g++) begin
        sample();
        chk("t5_gap_valid", 32'(sv[2]), 32'd0);
        chk("t5_gap_ready", 32'(lr[2]), 32'd0);
        chk("t5_gap_busy", 32'(bsy[2]), 32'd1);
        adv();
      end
      sample();
      chk("t5_idle_ready", 32'(lr[2]), 32'd1);
      chk("t5_idle_busy", 32'(bsy[2]), 32'd0);
      adv();
      lv[2] = 1'b0;
    end

    // 6: reset in the middle of 8'h55
    din[0] = 8'h55;
    lv[0]  = 1'b1;
    sample();
    adv();
    lv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      adv();
    end
    chk("t6_pre_idx", 32'(idx[0]), 32'd4);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(sv[0]), 32'd0);
    chk("t6_rst_busy", 32'(bsy[0]), 32'd0);
    chk("t6_rst_idx", 32'(idx[0]), 32'd0);
    chk("t6_rst_last", 32'(sl[0]), 32'd0);
    chk("t6_rst_ready", 32'(lr[0]), 32'd0);
    sbq[0].delete();
    sample();
    adv();
    rst = 1'b0;
    din[0] = 8'h01;
    lv[0]  = 1'b1;
    sample();
    chk("t6_ready_after", 32'(lr[0]), 32'd1);
    adv();
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t6_out", 32'(so[0]), (i == 0) ? 32'd1 : 32'd0);
      chk("t6_last", 32'(sl[0]), (i == 7) ? 32'd1 : 32'd0);
      adv();
    end
    sample();
    chk("t6_busy_after", 32'(bsy[0]), 32'd0);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb_drain[%0d]", k), 32'(sbq[k].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
